johnson_seq_ctrl: RTL and testbench

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

---
 rtl/johnson_ctrl_pkg.sv | 21 ++
 rtl/johnson_core.sv | 25 ++
 rtl/johnson_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_ctrl_pkg.sv
// Shared types and constants for the Johnson sequence controller.
// Also holds the detector for the two codes a 3-bit Johnson ring never reaches.
package johnson_ctrl_pkg;

  localparam int JOHNSON_W = 3;

  localparam logic [JOHNSON_W-1:0] ILLEGAL_A = 3'b010;
  localparam logic [JOHNSON_W-1:0] ILLEGAL_B = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  function automatic logic is_illegal(input logic [JOHNSON_W-1:0] code);
    return (code == ILLEGAL_A) || (code == ILLEGAL_B);
  endfunction

endpackage

// File: rtl/johnson_core.sv
// 3-bit Johnson phase register; shifts left by one bit, taking in shift_in.
// The controller decides when to shift and what bit enters.
module johnson_core
  import johnson_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 shift_en,
  input  logic                 shift_in,
  output logic [JOHNSON_W-1:0] phase
);

  logic [JOHNSON_W-1:0] phase_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      phase_q <= '0;
    end else if (shift_en) begin
      phase_q <= {phase_q[JOHNSON_W-2:0], shift_in};
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencer that advances a Johnson phase a requested number of steps, then
// flushes it back to 000 and pulses done; handles hold, abort and illegal codes.
module johnson_seq_ctrl
  import johnson_ctrl_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [STEP_W-1:0]    steps,
  input  logic                 hold,
  input  logic                 abort,
  output logic                 ready,
  output logic                 busy,
  output logic [JOHNSON_W-1:0] state,
  output logic [STEP_W-1:0]    steps_left,
  output logic                 done,
  output logic                 aborted,
  output logic                 illegal
);

  fsm_t              fsm_q, fsm_d;
  logic [STEP_W-1:0] steps_left_q, steps_left_d;
  logic              illegal_q, illegal_d;
  logic              aborted_q, aborted_d;
  logic              shift_en, shift_in;
  logic              code_bad;

  johnson_core u_core (
    .clock    (clock),
    .clear_n  (clear_n),
    .shift_en (shift_en),
    .shift_in (shift_in),
    .phase    (state)
  );

  assign code_bad = is_illegal(state);

  always_comb begin
    fsm_d        = fsm_q;
    steps_left_d = steps_left_q;
    illegal_d    = illegal_q;
    aborted_d    = aborted_q;
    shift_en     = 1'b0;
    shift_in     = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          illegal_d = 1'b0;
          aborted_d = 1'b0;
          if (steps != '0) begin
            steps_left_d = steps;
            fsm_d        = RUN;
          end else begin
            fsm_d = DONE;
          end
        end
      end
      RUN: begin
        // abort beats both hold and the final advance
        if (abort) begin
          aborted_d = 1'b1;
          fsm_d     = FLUSH;
        end else if (!hold) begin
          shift_en = 1'b1;
          shift_in = ~state[JOHNSON_W-1];
          if (steps_left_q != '0) begin
            steps_left_d = steps_left_q - STEP_W'(1);
          end
          if (steps_left_q == STEP_W'(1) || steps_left_q == '0) begin
            fsm_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (state != '0) begin
          shift_en = 1'b1;
        end else begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    // An unreachable code overrides normal sequencing; FLUSH keeps draining it.
    if (code_bad) begin
      illegal_d    = 1'b1;
      aborted_d    = 1'b1;
      steps_left_d = steps_left_q;
      fsm_d        = FLUSH;
      if (fsm_q != FLUSH) begin
        shift_en = 1'b0;
      end
      shift_in = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      fsm_q        <= IDLE;
      steps_left_q <= '0;
      illegal_q    <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      steps_left_q <= steps_left_d;
      illegal_q    <= illegal_d;
      aborted_q    <= aborted_d;
    end
  end

  assign ready      = (fsm_q == IDLE);
  assign busy       = (fsm_q == RUN) || (fsm_q == FLUSH);
  assign done       = (fsm_q == DONE);
  assign aborted    = aborted_q;
  assign illegal    = illegal_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl: each scenario task drives stimulus at the
// falling edge and compares outputs against hand-computed per-cycle expectations.
module tb_johnson_seq_ctrl;

  localparam int STEP_W = 8;

  logic              clock = 1'b0;
  logic              clear_n;
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              hold;
  logic              abort;
  logic              ready, busy, done, aborted, illegal;
  logic [2:0]        state;
  logic [STEP_W-1:0] steps_left;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  johnson_seq_ctrl #(.STEP_W(STEP_W)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .steps      (steps),
    .hold       (hold),
    .abort      (abort),
    .ready      (ready),
    .busy       (busy),
    .state      (state),
    .steps_left (steps_left),
    .done       (done),
    .aborted    (aborted),
    .illegal    (illegal)
  );

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; steps = '0; hold = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({ready, busy, done, aborted, illegal, state, steps_left} !== {5'b10000, 3'b000, 8'd0}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b busy=%b done=%b abt=%b ill=%b state=%b left=%0d, expected 1 0 0 0 0 000 0",
               ready, busy, done, aborted, illegal, state, steps_left);
    end
    clear_n = 1'b1;
    @(negedge clock);
    vectors++;
    if ({ready, busy, state} !== {2'b10, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b busy=%b state=%b, expected 1 0 000", ready, busy, state);
    end
  endtask

  task automatic test_steps3();
    logic [2:0]        es [9];
    logic [STEP_W-1:0] el [9];
    logic              ed [9];
    logic              eb [9];
    es = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000};
    el = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    start = 1'b1; steps = 8'd3;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if ({state, steps_left, done, busy} !== {es[i], el[i], ed[i], eb[i]}) begin
        miscompares++;
        $display("FAIL steps3[%0d]: state=%b left=%0d done=%b busy=%b, expected %b %0d %b %b",
                 i, state, steps_left, done, busy, es[i], el[i], ed[i], eb[i]);
      end
      if (i == 7) begin
        vectors++;
        if (aborted !== 1'b0) begin
          miscompares++;
          $display("FAIL steps3_aborted: aborted=%b, expected 0", aborted);
        end
      end
      @(negedge clock);
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL steps3_ready: ready=%b, expected 1", ready);
    end
  endtask

  task automatic test_full_cycle_and_zero();
    logic [2:0]        es [9];
    logic [STEP_W-1:0] el [9];
    logic              ed [9];
    logic              eb [9];
    es = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000};
    el = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    start = 1'b1; steps = 8'd6;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if ({state, steps_left, done, busy} !== {es[i], el[i], ed[i], eb[i]}) begin
        miscompares++;
        $display("FAIL steps6[%0d]: state=%b left=%0d done=%b busy=%b, expected %b %0d %b %b",
                 i, state, steps_left, done, busy, es[i], el[i], ed[i], eb[i]);
      end
      @(negedge clock);
    end
    start = 1'b1; steps = 8'd0;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if ({done, aborted, busy, ready, state} !== {4'b1000, 3'b000}) begin
      miscompares++;
      $display("FAIL steps0_done: done=%b abt=%b busy=%b rdy=%b state=%b, expected 1 0 0 0 000",
               done, aborted, busy, ready, state);
    end
    @(negedge clock);
    vectors++;
    if ({done, ready, state} !== {2'b01, 3'b000}) begin
      miscompares++;
      $display("FAIL steps0_after: done=%b rdy=%b state=%b, expected 0 1 000", done, ready, state);
    end
  endtask

  task automatic test_hold();
    logic [2:0]        es [5];
    logic [STEP_W-1:0] el [5];
    es = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
    el = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    start = 1'b1; steps = 8'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({state, steps_left} !== {3'b011, 8'd3}) begin
      miscompares++;
      $display("FAIL hold_pre: state=%b left=%0d, expected 011 3", state, steps_left);
    end
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if ({state, steps_left, busy} !== {3'b011, 8'd3, 1'b1}) begin
        miscompares++;
        $display("FAIL hold_frozen[%0d]: state=%b left=%0d busy=%b, expected 011 3 1",
                 i, state, steps_left, busy);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vectors++;
      if ({state, steps_left, busy} !== {es[i], el[i], 1'b1}) begin
        miscompares++;
        $display("FAIL hold_resume[%0d]: state=%b left=%0d busy=%b, expected %b %0d 1",
                 i, state, steps_left, busy, es[i], el[i]);
      end
      if (i == 3) break;
    end
    @(negedge clock);
    vectors++;
    if ({done, aborted} !== 2'b10) begin
      miscompares++;
      $display("FAIL hold_done: done=%b abt=%b, expected 1 0", done, aborted);
    end
    @(negedge clock);
  endtask

  task automatic test_abort();
    start = 1'b1; steps = 8'd10;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({state, steps_left} !== {3'b111, 8'd7}) begin
      miscompares++;
      $display("FAIL abort_pre: state=%b left=%0d, expected 111 7", state, steps_left);
    end
    abort = 1'b1; start = 1'b1; steps = 8'd3;
    @(negedge clock);
    abort = 1'b0;
    vectors++;
    if ({state, steps_left, busy, aborted} !== {3'b111, 8'd7, 2'b11}) begin
      miscompares++;
      $display("FAIL abort_hit: state=%b left=%0d busy=%b abt=%b, expected 111 7 1 1",
               state, steps_left, busy, aborted);
    end
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if ({state, steps_left, busy} !== {3'b110, 8'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_flush: state=%b left=%0d busy=%b, expected 110 7 1", state, steps_left, busy);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if ({done, aborted, state, steps_left} !== {2'b11, 3'b000, 8'd7}) begin
      miscompares++;
      $display("FAIL abort_done: done=%b abt=%b state=%b left=%0d, expected 1 1 000 7",
               done, aborted, state, steps_left);
    end
    @(negedge clock);
    vectors++;
    if ({ready, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_idle: rdy=%b done=%b, expected 1 0", ready, done);
    end
  endtask

  task automatic test_illegal();
    start = 1'b1; steps = 8'd10;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    force dut.u_core.phase_q = 3'b101;
    @(negedge clock);
    vectors++;
    if ({illegal, aborted, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL illegal_flag: ill=%b abt=%b busy=%b, expected 1 1 1", illegal, aborted, busy);
    end
    release dut.u_core.phase_q;
    for (int i = 0; i < 3 && state !== 3'b000; i++) @(negedge clock);
    vectors++;
    if (state !== 3'b000) begin
      miscompares++;
      $display("FAIL illegal_flush: state=%b, expected 000 within 3 edges", state);
    end
    @(negedge clock);
    vectors++;
    if ({done, aborted, illegal} !== 3'b111) begin
      miscompares++;
      $display("FAIL illegal_done: done=%b abt=%b ill=%b, expected 1 1 1", done, aborted, illegal);
    end
    @(negedge clock);
    start = 1'b1; steps = 8'd3;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if ({illegal, aborted, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL illegal_clear: ill=%b abt=%b busy=%b, expected 0 0 1", illegal, aborted, busy);
    end
    for (int i = 0; i < 12 && done !== 1'b1; i++) @(negedge clock);
    vectors++;
    if ({done, aborted} !== 2'b10) begin
      miscompares++;
      $display("FAIL illegal_rerun: done=%b abt=%b, expected 1 0", done, aborted);
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    start = 1'b1; steps = 8'd10;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (state !== 3'b111) begin
      miscompares++;
      $display("FAIL areset_pre: state=%b, expected 111", state);
    end
    #2 clear_n = 1'b0;
    #1;
    vectors++;
    if ({ready, busy, done, aborted, illegal, state, steps_left} !== {5'b10000, 3'b000, 8'd0}) begin
      miscompares++;
      $display("FAIL areset_now: rdy=%b busy=%b done=%b abt=%b ill=%b state=%b left=%0d, expected 1 0 0 0 0 000 0",
               ready, busy, done, aborted, illegal, state, steps_left);
    end
    @(negedge clock);
    clear_n = 1'b1; start = 1'b1; steps = 8'd3;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if ({busy, state, steps_left} !== {1'b1, 3'b000, 8'd3}) begin
      miscompares++;
      $display("FAIL areset_start: busy=%b state=%b left=%0d, expected 1 000 3", busy, state, steps_left);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if ({state, steps_left} !== {3'b111, 8'd0}) begin
      miscompares++;
      $display("FAIL areset_run: state=%b left=%0d, expected 111 0", state, steps_left);
    end
    for (int i = 0; i < 6 && done !== 1'b1; i++) @(negedge clock);
    vectors++;
    if ({done, aborted, state} !== {2'b10, 3'b000}) begin
      miscompares++;
      $display("FAIL areset_done: done=%b abt=%b state=%b, expected 1 0 000", done, aborted, state);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_steps3();
    test_full_cycle_and_zero();
    test_hold();
    test_abort();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
